// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate monitor: finds the decode latency of a Viterbi chain by searching
// lags against the reference stream, then counts compared bits and mismatches.
module viterbi_ber_checker #(
    parameter int MAX_LAT  = 64,
    parameter int LOCK_LEN = 16,
    parameter int WIN      = 32,
    parameter int LOSS_THR = 8,
    parameter int CW       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_i,
    input  logic                       ref_i,
    input  logic                       dec_i,
    input  logic                       clear_i,
    output logic                       locked_o,
    output logic [$clog2(MAX_LAT)-1:0] lag_o,
    output logic [CW-1:0]              bit_ct_o,
    output logic [CW-1:0]              err_ct_o,
    output logic                       err_o
);
    localparam int LW = $clog2(MAX_LAT);
    localparam int FW = LW + 1;
    localparam int RW = $clog2(LOCK_LEN + 1);
    localparam int WW = $clog2(WIN + 1);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]         state;
    logic [MAX_LAT-2:0] hist;
    logic [MAX_LAT-1:0] taps;
    logic [FW-1:0]      fill;
    logic [RW-1:0]      run;
    logic [WW-1:0]      win_cnt;
    logic [WW-1:0]      win_err;
    logic [WW-1:0]      win_err_nxt;
    logic               ref_at;
    logic               legal;
    logic               match;

    // taps[k] is the reference bit from k valid samples ago; tap 0 is the live input.
    assign taps        = {hist, ref_i};
    assign ref_at      = taps[lag_o];
    assign legal       = fill >= {1'b0, lag_o};
    assign match       = dec_i == ref_at;
    assign win_err_nxt = win_err + {{(WW-1){1'b0}}, ~match};
    assign locked_o    = state == ST_LOCKED;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_SEARCH;
            hist     <= '0;
            fill     <= '0;
            run      <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
            lag_o    <= '0;
            bit_ct_o <= '0;
            err_ct_o <= '0;
            err_o    <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (valid_i) begin
                hist <= {hist[MAX_LAT-3:0], ref_i};
                if (fill != FW'(MAX_LAT))
                    fill <= fill + FW'(1);
            end
            if (clear_i) begin
                bit_ct_o <= '0;
                err_ct_o <= '0;
                win_cnt  <= '0;
                win_err  <= '0;
            end
            if (valid_i && state == ST_SEARCH && legal) begin
                if (match) begin
                    if (run == RW'(LOCK_LEN - 1)) begin
                        state   <= ST_LOCKED;
                        run     <= '0;
                        win_cnt <= '0;
                        win_err <= '0;
                    end else begin
                        run <= run + RW'(1);
                    end
                end else begin
                    // power-of-2 depth makes the increment wrap to lag 0 by itself
                    run   <= '0;
                    lag_o <= lag_o + LW'(1);
                end
            end else if (valid_i && state == ST_LOCKED && !clear_i) begin
                if (bit_ct_o != '1)
                    bit_ct_o <= bit_ct_o + CW'(1);
                if (!match) begin
                    if (err_ct_o != '1)
                        err_ct_o <= err_ct_o + CW'(1);
                    err_o <= 1'b1;
                end
                if (win_cnt == WW'(WIN - 1)) begin
                    // retry the same lag first after a loss of lock
                    if (win_err_nxt >= WW'(LOSS_THR)) begin
                        state <= ST_SEARCH;
                        run   <= '0;
                    end
                    win_cnt <= '0;
                    win_err <= '0;
                end else begin
                    win_cnt <= win_cnt + WW'(1);
                    win_err <= win_err_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench: dec_i is the reference stream delayed 7 valid samples, with
// optional inversion, valid gaps, clears and asynchronous reset.
module tb_viterbi_ber_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0, ref_i = 1'b0, dec_i = 1'b0, clear_i = 1'b0;
    logic        locked_o, err_o, locked4, err4;
    logic [5:0]  lag_o, lag4;
    logic [31:0] bit_ct_o, err_ct_o;
    logic [3:0]  bit4, errc4;

    int   total = 0;
    int   bad   = 0;
    logic q[$];

    viterbi_ber_checker dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ref_i(ref_i), .dec_i(dec_i),
        .clear_i(clear_i), .locked_o(locked_o), .lag_o(lag_o), .bit_ct_o(bit_ct_o),
        .err_ct_o(err_ct_o), .err_o(err_o)
    );

    viterbi_ber_checker #(.CW(4)) dut4 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ref_i(ref_i), .dec_i(dec_i),
        .clear_i(clear_i), .locked_o(locked4), .lag_o(lag4), .bit_ct_o(bit4),
        .err_ct_o(errc4), .err_o(err4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    // one clock: drive at negedge, sample 1 time unit after the rising edge
    task automatic cyc(input logic v, input logic inv, input logic clr);
        logic d;
        @(negedge clk);
        d       = (q.size() >= 7) ? q[q.size()-7] : 1'b0;
        valid_i = v;
        clear_i = clr;
        ref_i   = 1'($urandom);
        dec_i   = d ^ inv;
        if (v) begin
            q.push_back(ref_i);
            if (q.size() > 64) void'(q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lock_up(input bit gaps, output int nval);
        logic v;
        nval = 0;
        while (!locked_o && nval < 400) begin
            v = gaps ? 1'($urandom) : 1'b1;
            cyc(v, 1'b0, 1'b0);
            if (v) nval++;
        end
    endtask

    initial begin
        int   n;
        int   k;
        logic relock;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", locked_o, 0);
        chk("rst_lag", lag_o, 0);
        chk("rst_bit", bit_ct_o, 0);
        chk("rst_err", err_ct_o, 0);
        chk("rst_err_o", err_o, 0);
        @(negedge clk);
        rst = 1'b1;

        // 1: clean delayed stream locks at lag 7, then counts one bit per valid
        lock_up(1'b0, n);
        chk("t1_locked", locked_o, 1);
        chk("t1_within_300", n <= 300, 1);
        chk("t1_lag", lag_o, 7);
        chk("t1_bit0", bit_ct_o, 0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("t1_bit20", bit_ct_o, 20);
        chk("t1_err", err_ct_o, 0);
        chk("t1_cw4_sat", bit4, 15);

        // 2: a flip on every 27th bit gives ten single-cycle err_o pulses
        for (int i = 0; i < 270; i++) begin
            cyc(1'b1, (i % 27) == 26, 1'b0);
            chk("t2_err_o", err_o, (i % 27) == 26);
        end
        chk("t2_err_ct", err_ct_o, 10);
        chk("t2_bit_ct", bit_ct_o, 290);
        chk("t2_locked", locked_o, 1);

        // 4: clear with a valid mismatching bit
        cyc(1'b1, 1'b1, 1'b1);
        chk("t4_bit", bit_ct_o, 0);
        chk("t4_err", err_ct_o, 0);
        chk("t4_err_o", err_o, 0);
        chk("t4_locked", locked_o, 1);

        // 3: continuous inversion drops lock at the first window boundary
        n = 0;
        while (locked_o && n < 40) begin
            cyc(1'b1, 1'b1, 1'b0);
            n++;
        end
        chk("t3_drop_at", n, 32);
        chk("t3_err", err_ct_o, 32);
        chk("t3_bit", bit_ct_o, 32);
        chk("t3_lag_held", lag_o, 7);
        cyc(1'b1, 1'b1, 1'b0);
        chk("t3_lag_next", lag_o, 8);
        relock = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            relock |= locked_o;
        end
        chk("t3_no_relock", relock, 0);
        chk("t3_err_frozen", err_ct_o, 32);

        // 6: relock, then asynchronous reset between edges
        lock_up(1'b0, n);
        chk("t6_relock", locked_o, 1);
        chk("t6_relock_lag", lag_o, 7);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_locked", locked_o, 0);
        chk("t6_async_lag", lag_o, 0);
        chk("t6_async_bit", bit_ct_o, 0);
        chk("t6_async_err", err_ct_o, 0);
        @(negedge clk);
        rst = 1'b1;
        lock_up(1'b0, n);
        chk("t6_lock", locked_o, 1);
        chk("t6_lag", lag_o, 7);

        // 5: same stream with random valid gaps
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        lock_up(1'b1, n);
        chk("t5_lock", locked_o, 1);
        chk("t5_lag", lag_o, 7);
        k = 0;
        for (int i = 0; i < 80 && k < 20; i++) begin
            if (i % 2 == 0 || (($urandom % 2) == 0 && i % 3 == 1)) begin
                cyc(1'b1, 1'b0, 1'b0);
                k++;
            end else begin
                cyc(1'b0, 1'b1, 1'b0);
            end
        end
        chk("t5_bit", bit_ct_o, 20);
        chk("t5_err", err_ct_o, 0);
        chk("t5_err_o", err_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
